// File: rtl/dm_arbiter_pkg.sv
// Shared constants and payload type for the data-memory arbiter.
// Optional aging/fixed-priority mode is enabled by defining DM_ARB_AGE_EN (undefined by default).
package dm_arbiter_pkg;

    localparam logic PORT_MEM = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int unsigned BE_W   = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned WAIT_W = 3;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [DW-1:0]   wd;
    } dm_wr_t;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection for the two DM requesters.
// FIXED_PRI=1 gives port 0 priority unless aging forces port 1; otherwise round-robin on last_gnt.
module dm_arb_pick
    import dm_arbiter_pkg::*;
#(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    input  logic age_force,
    output logic gnt0_c,
    output logic gnt1_c
);

    logic both_pick0;

    always_comb begin
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        both_pick0 = FIXED_PRI ? !age_force : (last_gnt == PORT_DMA);
        if (req0 && req1) begin
            gnt0_c = both_pick0;
            gnt1_c = !both_pick0;
        end else begin
            gnt0_c = req0;
            gnt1_c = req1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (MEM stage vs DMA).
// Define DM_ARB_AGE_EN for fixed priority with MAX_WAIT aging of the DMA port.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            we0,
    input  logic [BE_W-1:0] be0,
    input  logic [AW-1:0]   addr0,
    input  logic [DW-1:0]   wd0,
    input  logic            req1,
    input  logic            we1,
    input  logic [BE_W-1:0] be1,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wd1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [DW-1:0]   rdata,
    output logic            stall,
    output logic            dm_we,
    output logic [BE_W-1:0] dm_be,
    output logic [AW-1:0]   dm_addr,
    output logic [DW-1:0]   dm_wd,
    input  logic [DW-1:0]   dm_rd
);

    logic   last_gnt;
    logic   age_force;
    logic   pick0_c;
    logic   pick1_c;
    dm_wr_t sel_c;

    if (MAX_WAIT == 0 || MAX_WAIT > (2 ** WAIT_W) - 1) begin : g_bad_max_wait
        $error("dm_arbiter: MAX_WAIT must fit the wait counter");
    end

`ifdef DM_ARB_AGE_EN
    localparam bit FIXED_PRI = 1'b1;

    logic [WAIT_W-1:0] wait1;

    // DMA starvation counter; saturates at MAX_WAIT until port 1 wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait1 <= '0;
        end else if (gnt1) begin
            wait1 <= '0;
        end else if (req1 && (wait1 != WAIT_W'(MAX_WAIT))) begin
            wait1 <= wait1 + WAIT_W'(1);
        end
    end

    assign age_force = (wait1 == WAIT_W'(MAX_WAIT));
`else
    localparam bit FIXED_PRI = 1'b0;

    assign age_force = 1'b0;
`endif

    dm_arb_pick #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (last_gnt),
        .age_force (age_force),
        .gnt0_c    (pick0_c),
        .gnt1_c    (pick1_c)
    );

    // Grants are combinational but forced low while reset is held
    assign gnt0  = pick0_c & ~reset;
    assign gnt1  = pick1_c & ~reset;
    assign stall = req0 & gnt1;

    always_comb begin
        sel_c   = '0;
        dm_addr = '0;
        if (gnt0) begin
            sel_c   = '{we: we0, be: be0, wd: wd0};
            dm_addr = addr0;
        end else if (gnt1) begin
            sel_c   = '{we: we1, be: be1, wd: wd1};
            dm_addr = addr1;
        end
    end

    assign dm_we = sel_c.we;
    assign dm_be = sel_c.be;
    assign dm_wd = sel_c.wd;

    // Round-robin history and one-cycle read response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt <= PORT_DMA;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata    <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 || gnt1) begin
                last_gnt <= gnt1 ? PORT_DMA : PORT_MEM;
            end
            if ((gnt0 && !we0) || (gnt1 && !we1)) begin
                rdata <= dm_rd;
            end
        end
    end

    a_one_hot_gnt : assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: cycle model of grants/mux plus read-data scoreboard.
module tb_dm_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [3:0]  be0 = 0, be1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wd0 = 0, wd1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, stall, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] rdata, dm_addr, dm_wd, dm_rd;

    logic [31:0] mem [0:63];
    logic [31:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        last_m = 1'b1;
    int          wait_m = 0;
    logic        pend0_m = 0, pend1_m = 0;
    logic        keep0 = 0, keep1 = 0;

    dm_arbiter #(.AW(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .be0(be0), .addr0(addr0), .wd0(wd0),
        .req1(req1), .we1(we1), .be1(be1), .addr1(addr1), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .stall(stall), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    // Environment memory behind the DM port
    assign dm_rd = mem[dm_addr[7:2]];
    always @(posedge clk) begin
        if (dm_we) begin
            for (int b = 0; b < 4; b++)
                if (dm_be[b]) mem[dm_addr[7:2]][8*b +: 8] <= dm_wd[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        last_m  = 1'b1;
        wait_m  = 0;
        pend0_m = 1'b0;
        pend1_m = 1'b0;
        sb.delete();
    endtask

    // Assert reset now, check reset values asynchronously, release after two edges
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_rdata", rdata, 0);
        check("rst_dm_we", dm_we, 0);
        check("rst_dm_be", dm_be, 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_stall", stall, 0);
        model_clear();
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
        check("rst_rvalid0_edge", rvalid0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One clock: check combinational and registered outputs at negedge, advance model
    task automatic cycle(input bit rst_mid = 1'b0);
        logic        eg0, eg1, ewe;
        logic [3:0]  ebe;
        logic [31:0] eaddr, ewd, rexp;
        @(negedge clk);
        eg0 = 1'b0; eg1 = 1'b0;
        if (req0 && req1) begin
`ifdef DM_ARB_AGE_EN
            if (wait_m == MAXW) eg1 = 1'b1; else eg0 = 1'b1;
`else
            if (last_m) eg0 = 1'b1; else eg1 = 1'b1;
`endif
        end else begin
            eg0 = req0;
            eg1 = req1;
        end
        ewe = 0; ebe = 0; eaddr = 0; ewd = 0;
        if (eg0) begin ewe = we0; ebe = be0; eaddr = addr0; ewd = wd0; end
        if (eg1) begin ewe = we1; ebe = be1; eaddr = addr1; ewd = wd1; end
        check("gnt0", gnt0, eg0);
        check("gnt1", gnt1, eg1);
        check("stall", stall, req0 & eg1);
        check("dm_we", dm_we, ewe);
        check("dm_be", dm_be, ebe);
        check("dm_addr", dm_addr, eaddr);
        check("dm_wd", dm_wd, ewd);
        check("rvalid0", rvalid0, pend0_m);
        check("rvalid1", rvalid1, pend1_m);
        if (pend0_m || pend1_m) begin
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else begin
                rexp = sb.pop_front();
                check("rdata", rdata, rexp);
            end
        end
        pend0_m = eg0 & ~we0;
        pend1_m = eg1 & ~we1;
        if (pend0_m || pend1_m) sb.push_back(mem[eaddr[7:2]]);
        if (eg0 || eg1) last_m = eg1;
        if (eg1) wait_m = 0;
        else if (req1 && wait_m != MAXW) wait_m++;
        if (rst_mid) begin
            apply_reset();
        end else begin
            @(posedge clk); #1;
            if (eg0 && !keep0) req0 = 0;
            if (eg1 && !keep1) req1 = 0;
        end
    endtask

    task automatic set0(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        req0 = 1; we0 = we; be0 = be; addr0 = a; wd0 = d;
    endtask

    task automatic set1(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        req1 = 1; we1 = we; be1 = be; addr1 = a; wd1 = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        mem[4] = 32'hDEAD_BEEF;
        apply_reset();

        // Single read from MEM stage
        set0(0, 4'hF, 32'h10, 0);
        cycle();
        cycle();

        // Simultaneous writes after reset: port 0 first, then port 1
        apply_reset();
        set0(1, 4'hF, 32'h20, 32'hAAAA_0001);
        set1(1, 4'hF, 32'h24, 32'hBBBB_0002);
        cycle();
        cycle();
        cycle();

        // Continuous reads from both ports
        keep0 = 1; keep1 = 1;
        set0(0, 4'hF, 32'h40, 0);
        set1(0, 4'hF, 32'h44, 0);
        repeat (6) cycle();
        keep0 = 0; keep1 = 0;
        req0 = 0; req1 = 0;
        cycle();
        cycle();

        // Byte-lane write then read back
        set0(1, 4'b0100, 32'h30, 32'h7878_7878);
        cycle();
        set0(0, 4'hF, 32'h30, 0);
        cycle();
        cycle();
        check("sb_lane_data", mem[12], (32'h1000_0000 + 32'd12 * 32'h0101_0101) & 32'hFF00_FFFF | 32'h0078_0000);

        // Reset lands between a read grant and its response
        set0(0, 4'hF, 32'h10, 0);
        cycle(1'b1);
        cycle();
        cycle();

        // Long conflict run (aging pattern when enabled)
        keep0 = 1; keep1 = 1;
        set0(0, 4'hF, 32'h50, 0);
        set1(1, 4'h3, 32'h54, 32'h1234_5678);
        repeat (12) cycle();
        keep0 = 0; keep1 = 0;
        req0 = 0; req1 = 0;
        cycle();

        // Random mixed traffic
        for (int n = 0; n < 300; n++) begin
            if (!req0 && $urandom_range(0, 2) != 0)
                set0(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 32'($urandom_range(0, 63)) << 2, $urandom);
            if (!req1 && $urandom_range(0, 2) != 0)
                set1(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 32'($urandom_range(0, 63)) << 2, $urandom);
            cycle();
        end
        req0 = 0; req1 = 0;
        cycle();
        cycle();
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
